// File: rtl/cond_flag_unit.sv
// NZCV flag register, condition-code evaluation and write-strobe gating for the single-cycle CPU.
// Define COND_STATS_EN to add saturating executed/skipped instruction counters (exec_cnt_o, skip_cnt_o).
module cond_flag_unit #(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter int         CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             instr_valid_i,
    input  logic             stall_i,
    input  logic [3:0]       cond_i,
    input  logic [3:0]       alu_flags_i,
    input  logic [1:0]       flag_w_i,
    input  logic             reg_w_i,
    input  logic             mem_w_i,
    input  logic             pc_src_i,
    input  logic             no_write_i,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic             pc_src_o,
    output logic             cond_ex_o,
    output logic [3:0]       flags_o
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] exec_cnt_o,
    output logic [CNT_W-1:0] skip_cnt_o
`endif
);

    logic [3:0] flags_q;
    logic       n, z, c, v;
    logic       cond_pass;
    logic       issue;

    assign {n, z, c, v} = flags_q;

    // Evaluated against the registered flags only; no bypass from alu_flags_i.
    always_comb begin
        cond_pass = 1'b1;
        case (cond_i)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = ~z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = ~c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = ~n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = ~v;
            4'h8:    cond_pass = c & ~z;
            4'h9:    cond_pass = ~c | z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = ~z & (n == v);
            4'hD:    cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    end

    assign cond_ex_o   = instr_valid_i & cond_pass;
    assign reg_write_o = cond_ex_o & reg_w_i & ~no_write_i;
    assign mem_write_o = cond_ex_o & mem_w_i;
    assign pc_src_o    = cond_ex_o & pc_src_i;
    assign flags_o     = flags_q;

    assign issue = instr_valid_i & ~stall_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flags_q <= FLAGS_RST;
        end else if (issue && cond_pass) begin
            if (flag_w_i[1]) flags_q[3:2] <= alu_flags_i[3:2];
            if (flag_w_i[0]) flags_q[1:0] <= alu_flags_i[1:0];
        end
    end

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_q, skip_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            exec_q <= '0;
            skip_q <= '0;
        end else if (issue) begin
            if (cond_pass) begin
                if (exec_q != '1) exec_q <= exec_q + 1'b1;
            end else begin
                if (skip_q != '1) skip_q <= skip_q + 1'b1;
            end
        end
    end

    assign exec_cnt_o = exec_q;
    assign skip_cnt_o = skip_q;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: directed plan items followed by random instruction streams.
module tb_cond_flag_unit;

    localparam logic [3:0] FLAGS_RST = 4'b0000;
`ifdef COND_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0, stall = 1'b0;
    logic [3:0] cond = '0, alu_flags = '0;
    logic [1:0] flag_w = '0;
    logic       reg_w = 1'b0, mem_w = 1'b0, pc_src = 1'b0, no_write = 1'b0;
    logic       reg_write, mem_write, pc_src_out, cond_ex;
    logic [3:0] flags;
`ifdef COND_STATS_EN
    logic [CW-1:0] exec_cnt, skip_cnt;
`endif

    cond_flag_unit #(.FLAGS_RST(FLAGS_RST), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .instr_valid_i(instr_valid), .stall_i(stall),
        .cond_i(cond), .alu_flags_i(alu_flags), .flag_w_i(flag_w),
        .reg_w_i(reg_w), .mem_w_i(mem_w), .pc_src_i(pc_src), .no_write_i(no_write),
        .reg_write_o(reg_write), .mem_write_o(mem_write), .pc_src_o(pc_src_out),
        .cond_ex_o(cond_ex), .flags_o(flags)
`ifdef COND_STATS_EN
        , .exec_cnt_o(exec_cnt), .skip_cnt_o(skip_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         ce, rw, mw, ps;
        logic [3:0] fl;
        int         ec, sc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0, errors = 0;
    logic [3:0] m_flags = FLAGS_RST;
    int         m_exec = 0, m_skip = 0;

    // Odd codes invert the even base test; E and F always pass.
    function automatic bit pass_f(input logic [3:0] cd, input logic [3:0] f);
        bit fn, fz, fc, fv, b;
        {fn, fz, fc, fv} = f;
        case (cd[3:1])
            3'd0: b = fz;
            3'd1: b = fc;
            3'd2: b = fn;
            3'd3: b = fv;
            3'd4: b = fc && !fz;
            3'd5: b = (fn == fv);
            3'd6: b = !fz && (fn == fv);
            default: return 1'b1;
        endcase
        return cd[0] ? !b : b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One instruction per cycle; expectation reflects pre-edge model state.
    task automatic drive(input bit rst, input bit vl, input bit st, input logic [3:0] cd,
                         input logic [3:0] af, input logic [1:0] fw,
                         input bit rw, input bit mw, input bit ps, input bit nw);
        exp_t e;
        bit   p;
        @(negedge clk);
        rst_n = rst; instr_valid = vl; stall = st; cond = cd; alu_flags = af;
        flag_w = fw; reg_w = rw; mem_w = mw; pc_src = ps; no_write = nw;
        if (!rst) begin
            m_flags = FLAGS_RST; m_exec = 0; m_skip = 0;
        end
        p    = pass_f(cd, m_flags);
        e.ce = vl && p;
        e.rw = e.ce && rw && !nw;
        e.mw = e.ce && mw;
        e.ps = e.ce && ps;
        e.fl = m_flags;
        e.ec = m_exec;
        e.sc = m_skip;
        q.push_back(e);
        if (rst && vl && !st) begin
            if (p) begin
                if (fw[1]) m_flags[3:2] = af[3:2];
                if (fw[0]) m_flags[1:0] = af[1:0];
                if (m_exec < CMAX) m_exec++;
            end else if (m_skip < CMAX) m_skip++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                chk("cond_ex", cond_ex, e.ce);
                chk("reg_write", reg_write, e.rw);
                chk("mem_write", mem_write, e.mw);
                chk("pc_src", pc_src_out, e.ps);
                chk("flags", flags, e.fl);
`ifdef COND_STATS_EN
                chk("exec_cnt", exec_cnt, e.ec);
                chk("skip_cnt", skip_cnt, e.sc);
`endif
            end
        end
    end

    initial begin : stim
        // reset, EQ with Z=0 fails
        drive(0, 1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
        drive(1, 1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
        // AL writes 0110, then EQ passes and HI fails
        drive(1, 1, 0, 4'hE, 4'b0110, 2'b11, 0, 0, 0, 0);
        drive(1, 1, 0, 4'h0, 4'h0, 2'b00, 1, 0, 1, 0);
        drive(1, 1, 0, 4'h8, 4'h0, 2'b00, 1, 1, 1, 0);
        // N=1,V=0: LT passes, GE fails
        drive(1, 1, 0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
        drive(1, 1, 0, 4'hB, 4'h0, 2'b00, 0, 1, 0, 0);
        drive(1, 1, 0, 4'hA, 4'h0, 2'b00, 0, 1, 0, 0);
        // partial C,V update under NE, then failing EQ leaves flags
        drive(1, 1, 0, 4'hE, 4'b0000, 2'b11, 0, 0, 0, 0);
        drive(1, 1, 0, 4'h1, 4'b1111, 2'b01, 0, 0, 0, 0);
        drive(1, 1, 0, 4'h0, 4'b1111, 2'b11, 0, 0, 0, 0);
        drive(1, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        // stall holds flags; compare-class suppresses reg write
        drive(1, 1, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0);
        drive(1, 1, 0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 1);
        drive(1, 1, 0, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
        // mid-run reset must clear flags before the next edge
        drive(0, 1, 0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 4'hF, 4'h0, 2'b00, 1, 1, 1, 0);
        // five passes, two fails, stalls uncounted
        repeat (5) drive(1, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        repeat (2) drive(1, 1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        repeat (3) drive(1, 1, 1, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        drive(0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
        repeat (400) begin
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #4;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, 0 required", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
